// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM state type and frame geometry for the SPI command front end.
package spi_cmd_pkg;

  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;

  typedef enum logic [1:0] {IDLE, RECV, ISSUE, WAIT} rx_state_t;

  function automatic int frame_len(input int reg_width);
    return 16 + reg_width;
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for an asynchronous pin, with single-cycle rise/fall pulses.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_data,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta, r_sync, r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_data = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_shift_cmd_rx.sv
// SPI-slave command receiver: deserializes a shifter command, issues it, waits for
// completion and returns the result on MISO during the following frame.
module spi_shift_cmd_rx
  import spi_cmd_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [REG_WIDTH-1:0] op_a,
  output logic [4:0]           nbits,
  output logic [3:0]           opcode,
  output logic                 start,
  input  logic [REG_WIDTH-1:0] result,
  input  logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam int FL = frame_len(REG_WIDTH);
  localparam int CW = $clog2(FL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  rx_state_t            r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [FL-1:0]        r_rx;
  logic [REG_WIDTH-1:0] r_tx, r_op_a;
  logic [4:0]           r_nbits;
  logic [3:0]           r_opcode;
  logic [TW-1:0]        r_tmr;
  logic                 r_miso, r_err;

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_frame_ok, w_timeout, w_unused;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sclk (
    .i_clk(clock), .i_rst_n(reset), .i_pin(spi_sclk),
    .o_data(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_pin_sync #(.RST_VAL(1'b1)) u_cs (
    .i_clk(clock), .i_rst_n(reset), .i_pin(spi_cs_n),
    .o_data(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_pin_sync #(.RST_VAL(1'b0)) u_mosi (
    .i_clk(clock), .i_rst_n(reset), .i_pin(spi_mosi),
    .o_data(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  // Levels, MOSI edges and the reserved frame bits carry no information here.
  assign w_unused = ^{w_sclk_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall, r_rx[FL-5 -: 7]};

  assign w_frame_ok = (r_cnt == CW'(FL)) && op_legal(r_rx[FL-1 -: 4]);
  assign w_timeout  = (r_tmr == TW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_cs_fall) w_next = RECV;
      RECV:  if (w_cs_rise) w_next = w_frame_ok ? ISSUE : IDLE;
      ISSUE: w_next = WAIT;
      WAIT:  if (done || w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_rx     <= '0;
      r_tx     <= '0;
      r_op_a   <= '0;
      r_nbits  <= '0;
      r_opcode <= '0;
      r_tmr    <= '0;
      r_miso   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_cs_fall) begin
          r_cnt  <= '0;
          r_miso <= r_tx[REG_WIDTH-1];
        end
        RECV: begin
          if (w_sclk_rise && r_cnt != CW'(FL)) begin
            r_rx  <= {r_rx[FL-2:0], w_mosi};
            r_cnt <= r_cnt + 1'b1;
          end
          if (w_sclk_fall) begin
            r_miso <= r_tx[REG_WIDTH-2];
            r_tx   <= {r_tx[REG_WIDTH-2:0], 1'b0};
          end
          if (w_cs_rise) begin
            r_miso <= 1'b0;
            // Command fields are loaded on entry so they are valid while start is high.
            if (w_frame_ok) begin
              r_opcode <= r_rx[FL-1 -: 4];
              r_nbits  <= r_rx[REG_WIDTH +: 5];
              r_op_a   <= r_rx[REG_WIDTH-1:0];
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          r_err <= 1'b0;
          r_tmr <= '0;
        end
        WAIT: begin
          r_tmr <= r_tmr + 1'b1;
          if (done) begin
            r_tx <= result;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            r_tx  <= '1;
          end
        end
        default: ;
      endcase
      // A frame started while a command is outstanding is rejected and sees MISO low.
      if (w_cs_fall && (r_state == ISSUE || r_state == WAIT)) begin
        r_err  <= 1'b1;
        r_miso <= 1'b0;
      end
    end
  end

  assign start    = (r_state == ISSUE);
  assign busy     = (r_state == ISSUE) || (r_state == WAIT);
  assign err      = r_err;
  assign spi_miso = r_miso;
  assign op_a     = r_op_a;
  assign nbits    = r_nbits;
  assign opcode   = r_opcode;

endmodule

// File: tb/tb_spi_shift_cmd_rx.sv
// Directed bench for spi_shift_cmd_rx: SPI master tasks plus a simple shifter responder.
module tb_spi_shift_cmd_rx;

  logic        clock, reset, sclk, cs_n, mosi;
  logic        miso, start, busy, err, done;
  logic [31:0] op_a, result;
  logic [4:0]  nbits;
  logic [3:0]  opcode;

  logic        m_done = 1'b0;
  logic [31:0] m_res  = '0;
  int          m_cnt  = 0;
  int          m_lat  = 3;
  int          starts = 0;
  int          busy_cycles = 0;
  logic [3:0]  st_op  = '0;
  logic [4:0]  st_nb  = '0;
  logic [31:0] st_opa = '0;
  logic        man_done;
  logic [31:0] man_res;

  int n_run = 0;
  int n_fail = 0;

  assign done   = m_done | man_done;
  assign result = man_done ? man_res : m_res;

  spi_shift_cmd_rx #(.REG_WIDTH(32), .TIMEOUT(255)) dut (
    .clock(clock), .reset(reset), .spi_sclk(sclk), .spi_cs_n(cs_n),
    .spi_mosi(mosi), .spi_miso(miso), .op_a(op_a), .nbits(nbits),
    .opcode(opcode), .start(start), .result(result), .done(done),
    .busy(busy), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shifter responder: latches each start, answers after m_lat cycles (0 = never).
  always @(negedge clock) begin
    if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
    m_done <= (m_cnt == 1);
    if (m_cnt > 0) m_cnt <= m_cnt - 1;
    if (start === 1'b1) begin
      starts <= starts + 1;
      st_op  <= opcode;
      st_nb  <= nbits;
      st_opa <= op_a;
      m_res  <= (opcode == 4'b0110) ? (op_a << nbits) : (op_a >> nbits);
      if (m_lat > 0) m_cnt <= m_lat;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_frame(input logic [47:0] d, input int nb, output logic [47:0] cap);
    cap  = '0;
    cs_n = 1'b0;
    tick(8);
    for (int i = 0; i < nb; i++) begin
      mosi = d[47-i];
      tick(4);
      cap[47-i] = miso;
      sclk = 1'b1;
      tick(8);
      sclk = 1'b0;
      tick(4);
    end
    tick(8);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(8);
  endtask

  task automatic wait_start(input int prev, input string tag);
    int n = 0;
    while (starts <= prev && n < 40) begin tick(1); n++; end
    check(tag, 64'(starts), 64'(prev + 1));
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin tick(1); n++; end
    check(tag, 64'(busy), 64'd0);
  endtask

  logic [47:0] cap, cap2;
  int s0, bc0;

  initial begin
    reset = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    man_done = 1'b0; man_res = '0;
    tick(5);
    check("reset_outs", {op_a, nbits, opcode, start, miso, busy, err}, 64'd0);
    reset = 1'b1;
    tick(5);

    // Valid SHL by 4 of 0xF1
    m_lat = 3; s0 = starts;
    spi_frame(48'h60_04_000000F1, 48, cap);
    wait_start(s0, "t1_start");
    check("t1_opcode", 64'(st_op), 64'h6);
    check("t1_nbits", 64'(st_nb), 64'd4);
    check("t1_op_a", 64'(st_opa), 64'h000000F1);
    wait_idle(40, "t1_idle");
    check("t1_start_once", 64'(starts), 64'(s0 + 1));
    check("t1_err", 64'(err), 64'd0);

    // Valid SHR by 8; MISO returns previous result
    s0 = starts;
    spi_frame(48'h70_08_12345678, 48, cap);
    check("t2_miso", 64'(cap[47:16]), 64'h00000F10);
    wait_start(s0, "t2_start");
    check("t2_op_a", 64'(st_opa), 64'h12345678);
    check("t2_nbits", 64'(st_nb), 64'd8);
    wait_idle(40, "t2_idle");

    // Frame aborted after 20 bits
    s0 = starts;
    spi_frame(48'h60_04_000000F1, 20, cap);
    tick(10);
    check("abort_err", 64'(err), 64'd1);
    check("abort_nostart", 64'(starts), 64'(s0));
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_miso", 64'(cap[47:28]), 64'h00123);

    // Valid SHL by 31 clears err at ISSUE
    s0 = starts;
    spi_frame(48'h60_1F_00000001, 48, cap);
    wait_start(s0, "t3_start");
    tick(2);
    check("t3_nbits", 64'(st_nb), 64'd31);
    check("t3_err_clr", 64'(err), 64'd0);
    wait_idle(40, "t3_idle");

    // Illegal opcode, full length; MISO returns 0x80000000
    s0 = starts;
    spi_frame(48'h30_04_000000F1, 48, cap);
    tick(10);
    check("ill_miso", 64'(cap[47:16]), 64'h80000000);
    check("ill_err", 64'(err), 64'd1);
    check("ill_nostart", 64'(starts), 64'(s0));

    // Shifter never answers: timeout
    m_lat = 0; s0 = starts; bc0 = busy_cycles;
    spi_frame(48'h70_00_DEADBEEF, 48, cap);
    wait_start(s0, "to_start");
    wait_idle(400, "to_idle");
    check("to_busy_len", 64'(busy_cycles - bc0), 64'd256);
    check("to_err", 64'(err), 64'd1);

    // Frame during WAIT is rejected; late done still captured
    m_lat = 60; s0 = starts;
    spi_frame(48'h60_01_40000001, 48, cap);
    check("to_miso", 64'(cap[47:16]), 64'hFFFFFFFF);
    wait_start(s0, "cw_start");
    tick(2);
    check("cw_err_clr", 64'(err), 64'd0);
    check("cw_busy", 64'(busy), 64'd1);
    spi_frame(48'h60_02_00000003, 48, cap2);
    check("cw_miso_zero", 64'(cap2), 64'd0);
    check("cw_err", 64'(err), 64'd1);
    check("cw_nostart", 64'(starts), 64'(s0 + 1));
    check("cw_idle", 64'(busy), 64'd0);
    s0 = starts;
    spi_frame(48'h30_00_00000000, 48, cap);
    check("cw_readback", 64'(cap[47:16]), 64'h80000002);
    check("cw_rb_nostart", 64'(starts), 64'(s0));

    // Reset during WAIT, later done pulses ignored
    m_lat = 0; s0 = starts;
    spi_frame(48'h60_05_0000000F, 48, cap);
    wait_start(s0, "rst_start");
    tick(10);
    check("rst_pre_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_now", {op_a, nbits, opcode, start, miso, busy, err}, 64'd0);
    tick(2);
    man_res = 32'hA5A5A5A5; man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    tick(3);
    check("rst_after_done", {op_a, nbits, opcode, start, miso, busy, err}, 64'd0);
    spi_frame(48'h30_00_00000000, 48, cap);
    check("rst_tx_zero", 64'(cap[47:16]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_shift_cmd_rx.md
# spi_shift_cmd_rx

SPI-slave command front end that sits directly upstream of the barrel shifter. It deserializes a command frame from the external SPI master, issues one `start` pulse with `opcode`/`nbits`/`op_a` to the shifter and waits for `done`. It then captures `result` and shifts it back out on MISO during the next SPI frame. All logic runs in the single system clock domain; SPI pins are oversampled.

## Interface
- `REG_WIDTH`, 32: operand/result width.
- `TIMEOUT`, 255: maximum clock cycles to wait for `done` after `start`.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `spi_sclk` in 1: SPI clock, mode 0, asynchronous to `clock`.
- `spi_cs_n` in 1: SPI chip select, active-low.
- `spi_mosi` in 1: SPI data in, MSB first.
- `spi_miso` out 1: SPI data out, MSB first.
- `op_a` out REG_WIDTH: operand to the shifter.
- `nbits` out 5: shift amount.
- `opcode` out 4: shifter opcode.
- `start` out 1: one-cycle command strobe.
- `result` in REG_WIDTH: shifter result, valid when `done`=1.
- `done` in 1: shifter completion strobe.
- `busy` out 1: command outstanding (ISSUE or WAIT).
- `err` out 1: sticky error flag.

## Operation
- Frame: FRAME_LEN = 16+REG_WIDTH bits, MSB first.
  - Byte 0 = {opcode[3:0], 4'b0000}.
  - Byte 1 = {3'b000, nbits[4:0]}.
  - Then op_a[REG_WIDTH-1:0].
  - Reserved bits are ignored.
- MOSI is sampled on detected SCLK rising edge; MISO changes on detected SCLK falling edge.
- The first MISO bit is driven from `tx_reg` MSB when `spi_cs_n` falls.
- States:
  - IDLE: waiting for `spi_cs_n` falling edge. On that edge, clear the bit counter and go to RECV.
  - RECV: shift MOSI into `rx_reg`, shift `tx_reg` out on MISO, count bits. Bits beyond FRAME_LEN are ignored.
    - `spi_cs_n` rises with count == FRAME_LEN and opcode ∈ {OP_SHL, OP_SHR}: go to ISSUE.
    - Count != FRAME_LEN, or illegal opcode: set `err`, discard the frame, return to IDLE with no `start`.
  - ISSUE: load `op_a`/`nbits`/`opcode` from `rx_reg`, assert `start` for exactly one cycle, clear `err`, go to WAIT.
  - WAIT: outputs held stable.
    - `done`=1: capture `result` into `tx_reg`, go to IDLE.
    - Timer reaches TIMEOUT: set `err`, set `tx_reg` to all ones, go to IDLE.
- `spi_cs_n` falling while `busy`=1: set `err`. That frame is not received. MISO outputs 0 for its duration.
- `done` outside WAIT is ignored.
- Reset state:
  - `op_a`=0, `nbits`=0, `opcode`=0, `start`=0, `spi_miso`=0, `busy`=0, `err`=0.
  - `tx_reg`=0, state IDLE.
- Reset mid-frame or mid-WAIT aborts immediately. A later `done` is ignored.

## Timing
- `spi_sclk`, `spi_cs_n` and `spi_mosi` each pass through a 2-flop synchronizer.
- Edges are detected one cycle after synchronization, so edge latency is 3 `clock` cycles.
- Requirements on the SPI master:
  - `spi_sclk` high and low phases ≥ 4 `clock` cycles each.
  - `spi_cs_n` setup/hold to the first/last SCLK edge ≥ 4 cycles.
- `start` rises 1 cycle after the synchronized `spi_cs_n` rising edge is detected. `busy` rises in the same cycle.
- `tx_reg` is updated in the cycle `done` is sampled. `busy` falls the following cycle.
- `op_a`, `nbits` and `opcode` are stable from `start` until the next ISSUE.
- The timeout counter starts the cycle after `start`. `err` sets when the count reaches TIMEOUT.

## Structure
- Package `spi_cmd_pkg`:
  - `OP_SHL`=4'b0110, `OP_SHR`=4'b0111.
  - State enum `rx_state_t` {IDLE, RECV, ISSUE, WAIT}.
  - `FRAME_LEN` as a function of `REG_WIDTH`.
- Sub-module `spi_pin_sync`: 2-flop synchronizer plus rise/fall pulse outputs, instantiated for `spi_sclk` and `spi_cs_n`. `spi_mosi` uses its data output only.
- Top module: FSM, bit counter, `rx_reg`/`tx_reg` shift registers, timeout counter.

## Test plan
- Valid frame, opcode 0110, nbits 4, op_a 0x000000F1 → one-cycle `start` with those values. Shifter model returns `done` with 0x00000F10 after 3 cycles → `busy` falls. Next frame MISO = 0x00000F10 in the first 32 bits.
- Frame aborted after 20 bits → `err`=1, no `start`, state IDLE. Next valid frame clears `err` at ISSUE.
- Illegal opcode 0011 in a full-length frame → `err`=1, no `start`.
- Model never asserts `done` → after 255 cycles `err`=1, `busy`=0. Next frame MISO = 0xFFFFFFFF.
- `spi_cs_n` asserted during WAIT → `err`=1, frame ignored. Model's `done` still captured into `tx_reg`.
- `reset` asserted 10 cycles into WAIT → all outputs 0 immediately. A `done` pulse 2 cycles later → no change.
